uart_tx_arbiter: RTL and testbench

Round-robin arbiter that shares one UART transmitter between NUM_REQ byte producers. It selects a requester and latches its byte. It then issues a single-cycle tx_start to the transmitter and tracks the transmitter's busy flag until the frame completes. It sits between the producer blocks and the UART TX instance, and is the only driver of that instance's tx_start and data_in.

---
 rtl/uart_tx_arbiter.sv | 149 ++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter between NUM_REQ byte producers.
// Latches the winner's byte, pulses tx_start/ack, then follows tx_busy until the frame ends.
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int DATA_WIDTH   = 8,
  parameter int BUSY_TIMEOUT = 16,
  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            ack,
  output logic [NUM_REQ-1:0]            done,
  output logic                          tx_start,
  output logic [DATA_WIDTH-1:0]         tx_data,
  input  logic                          tx_busy,
  output logic [GW-1:0]                 grant_id,
  output logic                          active,
  output logic                          timeout_err
);

  localparam int TW = (BUSY_TIMEOUT > 2) ? $clog2(BUSY_TIMEOUT) : 1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [NUM_REQ-1:0]    ack_q, ack_d;
  logic [NUM_REQ-1:0]    done_q, done_d;
  logic                  tx_start_q, tx_start_d;
  logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
  logic [GW-1:0]         grant_id_q, grant_id_d;
  logic [GW-1:0]         last_grant_q, last_grant_d;
  logic                  active_q, active_d;
  logic                  timeout_q, timeout_d;
  logic [TW-1:0]         timer_q, timer_d;

  logic [DATA_WIDTH-1:0] slice [NUM_REQ];
  logic [GW:0]           idx;
  logic [GW-1:0]         win;
  logic                  found;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_slice
    assign slice[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
  end

  // Scan upward from the requester after the last grant, wrapping once around.
  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = {1'b0, last_grant_q} + (GW+1)'(k);
      if (idx >= (GW+1)'(NUM_REQ)) idx = idx - (GW+1)'(NUM_REQ);
      if (!found && req[idx[GW-1:0]]) begin
        found = 1'b1;
        win   = idx[GW-1:0];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    tx_data_d    = tx_data_q;
    grant_id_d   = grant_id_q;
    last_grant_d = last_grant_q;
    timer_d      = timer_q;
    ack_d        = '0;
    done_d       = '0;
    tx_start_d   = 1'b0;
    timeout_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (found && !tx_busy) begin
          tx_data_d  = slice[win];
          grant_id_d = win;
          tx_start_d = 1'b1;
          ack_d[win] = 1'b1;
          state_d    = START;
        end
      end
      START: begin
        timer_d = '0;
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        // A busy edge coinciding with expiry still counts as a started frame.
        if (tx_busy) begin
          state_d = WAIT_DONE;
        end else if (timer_q == TW'(BUSY_TIMEOUT-1)) begin
          timeout_d    = 1'b1;
          last_grant_d = grant_id_q;
          state_d      = IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          done_d[grant_id_q] = 1'b1;
          last_grant_d       = grant_id_q;
          state_d            = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    active_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      ack_q        <= '0;
      done_q       <= '0;
      tx_start_q   <= 1'b0;
      tx_data_q    <= '0;
      grant_id_q   <= '0;
      last_grant_q <= GW'(NUM_REQ-1);
      active_q     <= 1'b0;
      timeout_q    <= 1'b0;
      timer_q      <= '0;
    end else begin
      state_q      <= state_d;
      ack_q        <= ack_d;
      done_q       <= done_d;
      tx_start_q   <= tx_start_d;
      tx_data_q    <= tx_data_d;
      grant_id_q   <= grant_id_d;
      last_grant_q <= last_grant_d;
      active_q     <= active_d;
      timeout_q    <= timeout_d;
      timer_q      <= timer_d;
    end
  end

  assign ack         = ack_q;
  assign done        = done_q;
  assign tx_start    = tx_start_q;
  assign tx_data     = tx_data_q;
  assign grant_id    = grant_id_q;
  assign active      = active_q;
  assign timeout_err = timeout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: stimulus pushes expected grants/dones/timeouts,
// a negedge monitor pops and compares whenever the arbiter presents an event.
module tb_uart_tx_arbiter;
  localparam int NR = 4;
  localparam int DW = 8;
  localparam int BT = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic [NR-1:0]   req;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]   ack, done;
  logic            tx_start, tx_busy, active, timeout_err;
  logic [DW-1:0]   tx_data;
  logic [1:0]      grant_id;

  uart_tx_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .BUSY_TIMEOUT(BT)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .ack(ack), .done(done),
    .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy), .grant_id(grant_id),
    .active(active), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct { int id; logic [7:0] data; int gap; } start_t;
  typedef struct { int id; logic [7:0] data; } done_t;
  start_t exp_start[$];
  done_t  exp_done[$];
  int     exp_to[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int last_end_cyc = -100;
  int fall_cyc     = -100;
  int start_cyc    = -100;
  logic prev_busy  = 1'b0;
  logic uart_en    = 1'b1;
  int   uart_len   = 20;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc = cyc + 1;

  // UART model: busy rises the cycle after tx_start and stays up uart_len cycles.
  initial forever begin
    @(negedge clk);
    if (uart_en && tx_start && !rst) begin
      @(posedge clk); #1 tx_busy = 1'b1;
      repeat (uart_len) @(posedge clk);
      #1 tx_busy = 1'b0;
    end
  end

  // Monitor
  always @(negedge clk) begin
    start_t s;
    done_t  d;
    int     t;
    if (!rst) begin
      if (prev_busy && !tx_busy) fall_cyc = cyc;
      if (tx_start || ack != '0) begin
        chk("start_expected", 32'(exp_start.size() != 0), 1);
        if (exp_start.size() != 0) begin
          s = exp_start.pop_front();
          chk("start_pulse", 32'(tx_start), 1);
          chk("ack_onehot", 32'(ack), 32'(1) << s.id);
          chk("grant_id", 32'(grant_id), s.id);
          chk("tx_data", 32'(tx_data), 32'(s.data));
          chk("active_start", 32'(active), 1);
          if (s.gap == 1) chk("gap_after_end", cyc - last_end_cyc, 1);
          else if (s.gap == 2) chk("gap_after_busy_fall", cyc - fall_cyc, 1);
          start_cyc = cyc;
        end
      end
      if (done != '0) begin
        chk("done_expected", 32'(exp_done.size() != 0), 1);
        if (exp_done.size() != 0) begin
          d = exp_done.pop_front();
          chk("done_onehot", 32'(done), 32'(1) << d.id);
          chk("done_grant_id", 32'(grant_id), d.id);
          chk("done_tx_data_held", 32'(tx_data), 32'(d.data));
          chk("done_latency", cyc - fall_cyc, 1);
          chk("done_active", 32'(active), 0);
        end
        last_end_cyc = cyc;
      end
      if (timeout_err) begin
        chk("timeout_expected", 32'(exp_to.size() != 0), 1);
        if (exp_to.size() != 0) begin
          t = exp_to.pop_front();
          chk("timeout_grant_id", 32'(grant_id), t);
          chk("timeout_latency", cyc - start_cyc, BT + 1);
          chk("timeout_active", 32'(active), 0);
        end
        last_end_cyc = cyc;
      end
      if (ack != '0 || done != '0 || timeout_err)
        chk("event_exclusive", 32'(ack != '0) + 32'(done != '0) + 32'(timeout_err), 1);
    end
    prev_busy = tx_busy;
  end

  task automatic check_reset_outs();
    chk("rst_ack", 32'(ack), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_tx_start", 32'(tx_start), 0);
    chk("rst_tx_data", 32'(tx_data), 0);
    chk("rst_grant_id", 32'(grant_id), 0);
    chk("rst_active", 32'(active), 0);
    chk("rst_timeout_err", 32'(timeout_err), 0);
  endtask

  task automatic wait_ack(int idx);
    int n = 0;
    do begin @(negedge clk); n++; end while (!ack[idx] && n < 200);
    chk("wait_ack", 32'(ack[idx]), 1);
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin @(negedge clk); n++; end while ((active || tx_busy) && n < 200);
    chk("wait_idle", 32'(active), 0);
  endtask

  task automatic wait_busy();
    int n = 0;
    do begin @(negedge clk); n++; end while (!tx_busy && n < 200);
    chk("wait_busy", 32'(tx_busy), 1);
  endtask

  task automatic push_frame(int id, logic [7:0] data, int gap);
    exp_start.push_back('{id, data, gap});
    exp_done.push_back('{id, data});
  endtask

  initial begin
    rst = 1'b1; req = '0; req_data = '0; tx_busy = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); check_reset_outs();
    rst = 1'b0;

    // 1: single requester, data held while upstream slice changes
    req_data = 32'h33_22_A5_11;
    push_frame(1, 8'hA5, 0);
    @(negedge clk); req = 4'b0010;
    wait_ack(1);
    req = '0; req_data[15:8] = 8'h00;
    wait_idle();

    // 2: all requesting from fresh reset -> strict rotation 0..3 twice
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    req_data = 32'h13_12_11_10;
    for (int k = 0; k < 8; k++) push_frame(k % 4, 8'h10 + 8'(k % 4), (k == 0) ? 0 : 1);
    req = 4'b1111;
    for (int k = 0; k < 8; k++) wait_ack(k % 4);
    req = '0;
    wait_idle();

    // 3: wrap from 3 to 0, then a request arriving mid-frame waits for done
    push_frame(0, 8'h10, 0);
    req = 4'b1001;
    wait_ack(0);
    req = '0;
    wait_busy();
    repeat (2) @(negedge clk);
    push_frame(2, 8'h12, 1);
    req = 4'b0100;
    wait_ack(2);
    req = '0;
    wait_idle();

    // 4: transmitter never goes busy -> two timeouts, second grant right after first
    uart_en = 1'b0;
    exp_start.push_back('{0, 8'h10, 0}); exp_to.push_back(0);
    exp_start.push_back('{1, 8'h11, 1}); exp_to.push_back(1);
    req = 4'b0011;
    wait_ack(0);
    req = 4'b0010;
    wait_ack(1);
    req = '0;
    wait_idle();
    uart_en = 1'b1;

    // 5: reset in WAIT_DONE, then fresh grant once the line frees up
    req_data = 32'h13_C3_11_10;
    exp_start.push_back('{2, 8'hC3, 0});
    req = 4'b0100;
    wait_ack(2);
    req = '0;
    wait_busy();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1 check_reset_outs();
    @(negedge clk); rst = 1'b0;
    req_data[23:16] = 8'hC4;
    push_frame(2, 8'hC4, 2);
    req = 4'b0100;
    wait_ack(2);
    req = '0;
    wait_idle();

    // 6: busy held in IDLE blocks the grant until it falls
    uart_en = 1'b0;
    @(negedge clk);
    tx_busy = 1'b1;
    req_data[7:0] = 8'h77;
    push_frame(0, 8'h77, 2);
    req = 4'b0001;
    repeat (10) @(negedge clk);
    chk("no_grant_while_busy", 32'(active), 0);
    @(posedge clk); #1 tx_busy = 1'b0;
    wait_ack(0);
    req = '0;
    @(posedge clk); #1 tx_busy = 1'b1;
    repeat (3) @(posedge clk);
    #1 tx_busy = 1'b0;
    wait_idle();

    repeat (3) @(negedge clk);
    chk("start_queue_drained", exp_start.size(), 0);
    chk("done_queue_drained", exp_done.size(), 0);
    chk("timeout_queue_drained", exp_to.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (cyc %0d)", cyc);
    $fatal(1, "watchdog");
  end
endmodule
